// File: rtl/serial_sum_receiver.sv
// Bit-serial adder receiver: two LSB-first operand streams are summed into a
// WIDTH-bit result. Define SERIAL_SUB_EN to add the 'sub' port (A-B mode).
module serial_sum_receiver #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             a_bit,
  input  logic             b_bit,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             done,
  output logic             busy
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             carry_reg, carry_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic             full_reg, full_next;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             done_reg;

  logic frame_start, accept, mode, c_in, b_eff, s_bit, c_out;

`ifdef SERIAL_SUB_EN
  logic sub_reg;
`endif

  // Bit 0 takes its mode and carry seed from the live inputs, later bits from state.
  always_comb begin
    frame_start = start & bit_valid;
    accept      = bit_valid & (start | (state_reg == SHIFT));
`ifdef SERIAL_SUB_EN
    mode        = frame_start ? sub : sub_reg;
`else
    mode        = 1'b0;
`endif
    c_in        = frame_start ? mode : carry_reg;
    b_eff       = b_bit ^ mode;
    s_bit       = a_bit ^ b_eff ^ c_in;
    c_out       = (a_bit & b_eff) | (a_bit & c_in) | (b_eff & c_in);
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    carry_next = carry_reg;
    shreg_next = shreg_reg;
    full_next  = 1'b0;
    if (accept) begin
      carry_next = c_out;
      if (frame_start) begin
        // Also covers an abort: any partial frame is simply overwritten.
        shreg_next = {s_bit, {(WIDTH-1){1'b0}}};
        cnt_next   = CW'(1);
        state_next = SHIFT;
      end else begin
        shreg_next = {s_bit, shreg_reg[WIDTH-1:1]};
        if (cnt_reg == LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
          full_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      shreg_reg <= '0;
      full_reg  <= 1'b0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      carry_reg <= carry_next;
      shreg_reg <= shreg_next;
      full_reg  <= full_next;
      done_reg  <= full_reg;
      // Publish one edge after completion; a new frame may already be loading.
      if (full_reg) begin
        sum_reg  <= shreg_reg;
        cout_reg <= carry_reg;
      end
    end
  end

`ifdef SERIAL_SUB_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sub_reg <= 1'b0;
    end else if (frame_start) begin
      sub_reg <= sub;
    end
  end
`endif

  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign done = done_reg;
  assign busy = (state_reg == SHIFT);

endmodule
